regfile: RTL

REGFILE -- requirements
Module: regfile

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_rdport.sv | 29 ++
 rtl/regfile.sv | 63 ++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: reset level, reserved null encoding and
// the special-register addresses of the datapath.
package regfile_pkg;

    localparam logic       RST_ENABLE    = 1'b1;
    localparam logic [3:0] NULL_REG_ADDR = 4'hF;

    localparam logic [3:0] REG_SP = 4'd8;
    localparam logic [3:0] REG_IH = 4'd9;
    localparam logic [3:0] REG_T  = 4'd10;
    localparam logic [3:0] REG_RA = 4'd11;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port: enable/null gating, write-back bypass, then
// the stored entry.
module regfile_rdport #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] NULL_REG = '1
) (
    input  logic                              re,
    input  logic [ADDR_W-1:0]                 raddr,
    input  logic                              we,
    input  logic [ADDR_W-1:0]                 waddr,
    input  logic [DATA_W-1:0]                 wdata,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]  mem,
    output logic [DATA_W-1:0]                 rdata
);

    always_comb begin
        rdata = '0;
        if (re && (raddr != NULL_REG)) begin
            // In-flight write-back wins over the stale stored value.
            if (we && (waddr == raddr)) begin
                rdata = wdata;
            end else begin
                rdata = mem[raddr];
            end
        end
    end

endmodule

// File: rtl/regfile.sv
// Two-read / one-write register file with same-cycle write-back bypass.
// The null entry is never written, so it stays at zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] NULL_REG = ADDR_W'(NULL_REG_ADDR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            mem <= '0;
        end else if (we && (waddr != NULL_REG)) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NULL_REG (NULL_REG)
    ) u_rdport1 (
        .re    (re1),
        .raddr (raddr1),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .mem   (mem),
        .rdata (rdata1)
    );

    regfile_rdport #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NULL_REG (NULL_REG)
    ) u_rdport2 (
        .re    (re2),
        .raddr (raddr2),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .mem   (mem),
        .rdata (rdata2)
    );

endmodule
